// File: rtl/sbox_stim_pkg.sv
// Shared types and constants for the Sbox chain stimulus/capture controller.
// The optional LFSR stimulus source is enabled with the SBOX_STIM_LFSR_EN macro.
package sbox_stim_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 4;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1: register bits 7,5,4,3 feed back
  localparam logic [7:0] LFSR_TAPS   = 8'hB8;
  // An all-zero LFSR never leaves zero, so a zero seed is swapped for this
  localparam logic [7:0] LFSR_SEED_NZ = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // One Fibonacci step: shift left, feedback is the XOR of the tapped bits
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sbox_stim_lfsr.sv
// 8-bit Fibonacci LFSR stimulus source for the chain data input.
// Only instantiated when SBOX_STIM_LFSR_EN is defined.
module sbox_stim_lfsr
  import sbox_stim_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] value
);

  // Seed load has priority over stepping; a zero seed is replaced by a nonzero one
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= (seed == 8'h00) ? LFSR_SEED_NZ : seed;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/sbox_stim_ctrl.sv
// Single-shot stimulus/capture wrapper around the 8-bit Sbox iteration chain.
// Accepts a command, loads the chain, waits WAIT_CYCLES while it iterates, then
// returns the captured chain output on a valid/ready result port.
// Optional feature macro: SBOX_STIM_LFSR_EN (LFSR-driven chain data during RUN).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; a producer holds valid and its payload stable until that edge, and a
// consumer may drive ready independently of valid.
module sbox_stim_ctrl
  import sbox_stim_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WAIT_CYCLES = 12,
  parameter int WAIT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_start,
  input  logic [DATA_W-1:0] cmd_value,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [DATA_W-1:0] chain_value_in,
  output logic [CNT_W-1:0]  chain_start,
  output logic              chain_rst,
  input  logic [DATA_W-1:0] chain_value_out,
  output logic              busy
);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept;

  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  // The chain is held in load while we are in reset as well as in LOAD
  assign chain_rst = rst || (state == ST_LOAD);

  // Control FSM: command latch, load pulse, RUN countdown, capture and result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      chain_start <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            chain_start <= cmd_start;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          wait_cnt <= WAIT_W'(WAIT_CYCLES);
          state    <= ST_RUN;
        end
        ST_RUN: begin
          wait_cnt <= wait_cnt - WAIT_W'(1);
          if (wait_cnt == WAIT_W'(1)) begin
            res_data  <= chain_value_out;
            res_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SBOX_STIM_LFSR_EN
  logic [7:0] lfsr_value;

  // Seeded on command accept so the seed is on the chain input during LOAD;
  // steps at the end of every RUN cycle.
  sbox_stim_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .seed  (8'(cmd_value)),
    .step  (state == ST_RUN),
    .value (lfsr_value)
  );

  assign chain_value_in = DATA_W'(lfsr_value);
`else
  logic [DATA_W-1:0] value_q;

  // Latched command value drives the chain input through LOAD and RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else if (accept) begin
      value_q <= cmd_value;
    end
  end

  assign chain_value_in = value_q;
`endif

endmodule
